// File: rtl/slc3_datapath_pkg.sv
// Shared LC-3 type definitions: opcodes, datapath mux encodings and
// sign/zero-extension helpers used by the SLC-3.2 datapath.
package lc3b_types;

    typedef enum logic [3:0] {
        op_br   = 4'b0000,
        op_add  = 4'b0001,
        op_ld   = 4'b0010,
        op_st   = 4'b0011,
        op_jsr  = 4'b0100,
        op_and  = 4'b0101,
        op_ldr  = 4'b0110,
        op_str  = 4'b0111,
        op_rti  = 4'b1000,
        op_not  = 4'b1001,
        op_ldi  = 4'b1010,
        op_sti  = 4'b1011,
        op_jmp  = 4'b1100,
        op_res  = 4'b1101,
        op_lea  = 4'b1110,
        op_trap = 4'b1111
    } lc3b_opcode_t;

    localparam logic [1:0] alu_add  = 2'b00;
    localparam logic [1:0] alu_and  = 2'b01;
    localparam logic [1:0] alu_not  = 2'b10;
    localparam logic [1:0] alu_pass = 2'b11;

    localparam logic [1:0] pcmux_inc   = 2'b00;
    localparam logic [1:0] pcmux_bus   = 2'b01;
    localparam logic [1:0] pcmux_adder = 2'b10;
    localparam logic [1:0] pcmux_hold  = 2'b11;

    localparam logic [1:0] addr2_zero  = 2'b00;
    localparam logic [1:0] addr2_off6  = 2'b01;
    localparam logic [1:0] addr2_off9  = 2'b10;
    localparam logic [1:0] addr2_off11 = 2'b11;

    localparam logic [1:0] drmux_ir11 = 2'b00;
    localparam logic [1:0] drmux_r7   = 2'b01;

    localparam logic [1:0] sr1mux_ir8  = 2'b00;
    localparam logic [1:0] sr1mux_ir11 = 2'b01;

    function automatic logic [15:0] sext5(input logic [4:0] v);
        return {{11{v[4]}}, v};
    endfunction

    function automatic logic [15:0] sext6(input logic [5:0] v);
        return {{10{v[5]}}, v};
    endfunction

    function automatic logic [15:0] sext9(input logic [8:0] v);
        return {{7{v[8]}}, v};
    endfunction

    function automatic logic [15:0] sext11(input logic [10:0] v);
        return {{5{v[10]}}, v};
    endfunction

    function automatic logic [15:0] zext8(input logic [7:0] v);
        return {8'h00, v};
    endfunction

endpackage

// File: rtl/slc3_datapath_reg_file.sv
// 8x16 general-purpose register file: one write port, two combinational
// read ports, asynchronous clear. Reads see the pre-edge value (no bypass).
module reg_file (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        ld,
    input  logic [2:0]  dr,
    input  logic [2:0]  sr1,
    input  logic [2:0]  sr2,
    input  logic [15:0] din,
    output logic [15:0] sr1_out,
    output logic [15:0] sr2_out
);

    logic [15:0] regs_r [8];

    // Register storage: cleared on Reset, written from the bus on ld.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < 8; i++) begin
                regs_r[i] <= 16'h0000;
            end
        end else if (ld) begin
            regs_r[dr] <= din;
        end
    end

    assign sr1_out = regs_r[sr1];
    assign sr2_out = regs_r[sr2];

endmodule

// File: rtl/slc3_datapath.sv
// SLC-3.2 register-transfer datapath: PC, IR, MAR, MDR, register file, ALU,
// address adder, condition codes and branch enable, driven by ISDU selects.
module slc3_datapath
    import lc3b_types::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        LD_MAR,
    input  logic        LD_MDR,
    input  logic        LD_IR,
    input  logic        LD_BEN,
    input  logic        LD_CC,
    input  logic        LD_REG,
    input  logic        LD_PC,
    input  logic        GatePC,
    input  logic        GateMDR,
    input  logic        GateALU,
    input  logic        GateMARMUX,
    input  logic [1:0]  PCMUX,
    input  logic [1:0]  DRMUX,
    input  logic [1:0]  SR1MUX,
    input  logic        SR2MUX,
    input  logic        ADDR1MUX,
    input  logic        MARMUX,
    input  logic [1:0]  ADDR2MUX,
    input  logic [1:0]  ALUK,
    input  logic        Mem_OE,
    input  logic [15:0] Data_from_SRAM,
    output logic [3:0]  Opcode,
    output logic        IR_5,
    output logic        BEN,
    output logic [15:0] MAR,
    output logic [15:0] MDR,
    output logic [15:0] PC,
    output logic [15:0] IR
);

    logic [15:0] pc_r, ir_r, mar_r, mdr_r;
    logic [2:0]  nzp_r;
    logic        ben_r;

    logic [15:0] bus_s, alu_s, adder_s, addr1_s, addr2_s, marmux_s, pc_next_s;
    logic [15:0] sr1_out_s, sr2_out_s, alu_b_s;
    logic [2:0]  sr1_sel_s, dr_sel_s, nzp_next_s;

    // Bus driver with fixed priority so overlapping gates stay deterministic.
    always_comb begin
        bus_s = 16'h0000;
        if (GatePC) begin
            bus_s = pc_r;
        end else if (GateMDR) begin
            bus_s = mdr_r;
        end else if (GateALU) begin
            bus_s = alu_s;
        end else if (GateMARMUX) begin
            bus_s = marmux_s;
        end else begin
            bus_s = 16'h0000;
        end
    end

    // Address adder operand selection and sum (wraps mod 2^16).
    always_comb begin
        addr1_s = ADDR1MUX ? sr1_out_s : pc_r;
        case (ADDR2MUX)
            addr2_zero:  addr2_s = 16'h0000;
            addr2_off6:  addr2_s = sext6(ir_r[5:0]);
            addr2_off9:  addr2_s = sext9(ir_r[8:0]);
            addr2_off11: addr2_s = sext11(ir_r[10:0]);
            default:     addr2_s = 16'h0000;
        endcase
        adder_s  = addr1_s + addr2_s;
        marmux_s = MARMUX ? zext8(ir_r[7:0]) : adder_s;
    end

    // Register-select decoding for SR1 and DR.
    always_comb begin
        case (SR1MUX)
            sr1mux_ir8:  sr1_sel_s = ir_r[8:6];
            sr1mux_ir11: sr1_sel_s = ir_r[11:9];
            default:     sr1_sel_s = ir_r[8:6];
        endcase
        case (DRMUX)
            drmux_ir11: dr_sel_s = ir_r[11:9];
            drmux_r7:   dr_sel_s = 3'd7;
            default:    dr_sel_s = ir_r[11:9];
        endcase
    end

    // ALU: operand B from SR2 or the 5-bit immediate.
    always_comb begin
        alu_b_s = SR2MUX ? sext5(ir_r[4:0]) : sr2_out_s;
        case (ALUK)
            alu_add:  alu_s = sr1_out_s + alu_b_s;
            alu_and:  alu_s = sr1_out_s & alu_b_s;
            alu_not:  alu_s = ~sr1_out_s;
            alu_pass: alu_s = sr1_out_s;
            default:  alu_s = sr1_out_s;
        endcase
    end

    // Next-PC source and condition-code derivation from the bus.
    always_comb begin
        case (PCMUX)
            pcmux_inc:   pc_next_s = pc_r + 16'h0001;
            pcmux_bus:   pc_next_s = bus_s;
            pcmux_adder: pc_next_s = adder_s;
            pcmux_hold:  pc_next_s = pc_r;
            default:     pc_next_s = pc_r;
        endcase
        nzp_next_s = {bus_s[15], (bus_s == 16'h0000), (~bus_s[15]) & (bus_s != 16'h0000)};
    end

    // Architectural registers; Reset overrides every load enable.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pc_r  <= RESET_PC;
            ir_r  <= 16'h0000;
            mar_r <= 16'h0000;
            mdr_r <= 16'h0000;
            nzp_r <= 3'b000;
            ben_r <= 1'b0;
        end else begin
            if (LD_PC)  pc_r  <= pc_next_s;
            if (LD_IR)  ir_r  <= bus_s;
            if (LD_MAR) mar_r <= bus_s;
            if (LD_MDR) mdr_r <= Mem_OE ? bus_s : Data_from_SRAM;
            if (LD_CC)  nzp_r <= nzp_next_s;
            if (LD_BEN) ben_r <= |(ir_r[11:9] & nzp_r);
        end
    end

    reg_file u_reg_file (
        .Clk     (Clk),
        .Reset   (Reset),
        .ld      (LD_REG),
        .dr      (dr_sel_s),
        .sr1     (sr1_sel_s),
        .sr2     (ir_r[2:0]),
        .din     (bus_s),
        .sr1_out (sr1_out_s),
        .sr2_out (sr2_out_s)
    );

    assign Opcode = ir_r[15:12];
    assign IR_5   = ir_r[5];
    assign BEN    = ben_r;
    assign MAR    = mar_r;
    assign MDR    = mdr_r;
    assign PC     = pc_r;
    assign IR     = ir_r;

endmodule
